// File: rtl/proc_isa_pkg.sv
// ---------------------------------------------------------------------------
// proc_isa_pkg
//  Shared ISA definitions for the decode stage, register file and execute
//  stage of the 8-bit teaching processor.
//  Contents:
//   - opcode constants for the upper nibble of an instruction byte
//   - cu_input encodings (Rb source select and shift-path control)
//   - decode FSM state encodings (kept as plain localparams so older
//     blocks that compare against raw 2-bit codes keep working)
//   - ctrl_t: the bundle of register-file controls produced by decode
//   - decode_instr(): maps one instruction byte to its ctrl_t
// ---------------------------------------------------------------------------
package proc_isa_pkg;

    // Upper-nibble opcodes. Ops 1..5 are the Ra-writing ALU group.
    localparam logic [3:0] OP_SYS   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_SHIFT = 4'd6;
    localparam logic [3:0] OP_STACK = 4'd7;
    localparam logic [3:0] OP_RBALU = 4'd8;
    localparam logic [3:0] OP_JZ    = 4'd9;
    localparam logic [3:0] OP_JN    = 4'd10;
    localparam logic [3:0] OP_JC    = 4'd11;
    localparam logic [3:0] OP_MEM   = 4'd12;
    localparam logic [3:0] OP_LOAD  = 4'd13;

    // cu_input: [1:0] Rb source, [2] rotate direction, [3] shift path.
    localparam logic [3:0] CU_MEM  = 4'b0000;
    localparam logic [3:0] CU_PORT = 4'b0001;
    localparam logic [3:0] CU_IMM  = 4'b0010;
    localparam logic [3:0] CU_ALU  = 4'b0011;
    localparam logic [3:0] CU_RLC  = 4'b1000;
    localparam logic [3:0] CU_RRC  = 4'b1100;

    // Decode FSM states.
    localparam logic [1:0] S_DEC   = 2'd0;
    localparam logic [1:0] S_IMM   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] ra_add;
        logic [1:0] rb_add;
        logic [3:0] cu_input;
        logic       ra_en;
        logic       rb_en;
        logic       flags_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       port_out;
        logic       branch;
    } ctrl_t;

    // A bubble is an all-zero control word, identical to NOP.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // LDM is op12 with ra field 0; its immediate follows in the next byte.
    function automatic logic is_ldm(input logic [7:0] instr);
        return (instr[7:4] == OP_MEM) && (instr[3:2] == 2'd0);
    endfunction

    // HLT is op0 with ra field 1.
    function automatic logic is_hlt(input logic [7:0] instr);
        return (instr[7:4] == OP_SYS) && (instr[3:2] == 2'd1);
    endfunction

    // Single-byte decode. LDM, HLT and all unused encodings give a bubble;
    // the FSM handles the sequencing side of LDM and HLT.
    function automatic ctrl_t decode_instr(input logic [7:0] instr);
        ctrl_t      c;
        logic [1:0] ra;
        ra         = instr[3:2];
        c          = CTRL_BUBBLE;
        c.opcode   = instr[7:4];
        c.ra_add   = ra;
        c.rb_add   = instr[1:0];
        case (instr[7:4])
            OP_MOV: c.ra_en = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.ra_en    = 1'b1;
                c.flags_en = 1'b1;
            end
            OP_SHIFT: begin
                c.flags_en = 1'b1;
                if (ra == 2'd0) begin
                    c.rb_en    = 1'b1;
                    c.cu_input = CU_RLC;
                end else if (ra == 2'd1) begin
                    c.rb_en    = 1'b1;
                    c.cu_input = CU_RRC;
                end
            end
            OP_STACK: begin
                case (ra)
                    2'd0: c.mem_wr = 1'b1;
                    2'd1: begin
                        c.rb_en    = 1'b1;
                        c.cu_input = CU_MEM;
                        c.mem_rd   = 1'b1;
                    end
                    2'd2: c.port_out = 1'b1;
                    default: begin
                        c.rb_en    = 1'b1;
                        c.cu_input = CU_PORT;
                    end
                endcase
            end
            OP_RBALU: begin
                c.rb_en    = 1'b1;
                c.cu_input = CU_ALU;
                c.flags_en = 1'b1;
            end
            OP_JZ, OP_JN, OP_JC: c.branch = 1'b1;
            OP_MEM: begin
                case (ra)
                    2'd0: c = CTRL_BUBBLE;
                    2'd1: begin
                        c.rb_en    = 1'b1;
                        c.cu_input = CU_MEM;
                        c.mem_rd   = 1'b1;
                    end
                    default: c.mem_wr = 1'b1;
                endcase
            end
            OP_LOAD: begin
                c.rb_en    = 1'b1;
                c.cu_input = CU_MEM;
                c.mem_rd   = 1'b1;
            end
            default: c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_hazard_detect.sv
// ---------------------------------------------------------------------------
// decode_hazard_detect
//  Combinational load-use hazard check for the decode stage.
//  Ports:
//   prev_load  in  1  instruction now in execute writes Rb from memory
//   prev_rb    in  2  register that load writes
//   cur_ra     in  2  ra field of the byte being decoded
//   cur_rb     in  2  rb field of the byte being decoded
//   hazard     out 1  current byte must wait for the load data
// ---------------------------------------------------------------------------
module decode_hazard_detect (
    input  logic       prev_load,
    input  logic [1:0] prev_rb,
    input  logic [1:0] cur_ra,
    input  logic [1:0] cur_rb,
    output logic       hazard
);

    assign hazard = prev_load && ((cur_ra == prev_rb) || (cur_rb == prev_rb));

endmodule

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//  Decode stage feeding the register file. Accepts instruction bytes over a
//  valid/ready handshake, produces registered register-file controls one
//  cycle later, sequences two-byte LDM, inserts load-use bubbles and halts
//  on HLT.
//  Parameters:
//   DATA_W        instruction width, fixed at 8 by the ISA
//   STALL_CYCLES  bubbles per load-use hazard (1..3)
//   CNT_W         stall counter width (only with DECODE_PERF_CNT_EN)
//  Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_i/valid/ready instruction byte handshake from fetch
//   flush_i             kill decode contents (taken branch)
//   opcode_o, ra_add_o, rb_add_o, cu_input_o, ra_en_o, rb_en_o, flags_en_o
//                       register-file controls
//   mem_rd_o, mem_wr_o, port_out_o, branch_o
//                       strobes for the downstream stages
//   halted_o            stage is halted
//   perf_stall_cnt_o    saturating count of hazard bubbles
//  Configuration macro: DECODE_PERF_CNT_EN adds the stall counter and its
//  port; without it the stage behaves identically minus the counter.
// ---------------------------------------------------------------------------
module instr_decode_stage
    import proc_isa_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int STALL_CYCLES = 1
`ifdef DECODE_PERF_CNT_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic              flush_i,
    output logic [3:0]        opcode_o,
    output logic [1:0]        ra_add_o,
    output logic [1:0]        rb_add_o,
    output logic [3:0]        cu_input_o,
    output logic              ra_en_o,
    output logic              rb_en_o,
    output logic              flags_en_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic              port_out_o,
    output logic              branch_o,
    output logic              halted_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt_o
`endif
);

    // The stall-cycle counter preloads with the bubbles still owed after
    // the one emitted on the cycle the hazard is detected.
    localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic [1:0]        ldm_rb_q, ldm_rb_d;
    logic [1:0]        stall_left_q, stall_left_d;
    logic              stall_bubble;
    logic              issue_en;
    logic [DATA_W-1:0] issue_byte;
    logic              prev_load;
    logic              hazard;

    // The instruction whose controls sit on the outputs is the one now in
    // execute; if it loads Rb from memory its data is not yet available.
    assign prev_load = ctrl_q.rb_en && (ctrl_q.cu_input == CU_MEM);

    decode_hazard_detect u_hazard (
        .prev_load (prev_load),
        .prev_rb   (ctrl_q.rb_add),
        .cur_ra    (instr_i[3:2]),
        .cur_rb    (instr_i[1:0]),
        .hazard    (hazard)
    );

    // Ready follows the state register, except that a flush cycle always
    // accepts (and discards) whatever fetch is presenting.
    assign instr_ready_o = flush_i || (state_q == S_DEC) || (state_q == S_IMM);
    assign halted_o      = (state_q == S_HALT);

    assign opcode_o   = ctrl_q.opcode;
    assign ra_add_o   = ctrl_q.ra_add;
    assign rb_add_o   = ctrl_q.rb_add;
    assign cu_input_o = ctrl_q.cu_input;
    assign ra_en_o    = ctrl_q.ra_en;
    assign rb_en_o    = ctrl_q.rb_en;
    assign flags_en_o = ctrl_q.flags_en;
    assign mem_rd_o   = ctrl_q.mem_rd;
    assign mem_wr_o   = ctrl_q.mem_wr;
    assign port_out_o = ctrl_q.port_out;
    assign branch_o   = ctrl_q.branch;

    // Next-state and next-control logic. Every path starts from a bubble;
    // only an issued instruction or an LDM immediate overrides it. Issuing
    // is shared between a freshly accepted byte and the byte held during a
    // stall, so LDM and HLT sequencing works the same for both.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = CTRL_BUBBLE;
        held_d       = held_q;
        ldm_rb_d     = ldm_rb_q;
        stall_left_d = stall_left_q;
        stall_bubble = 1'b0;
        issue_en     = 1'b0;
        issue_byte   = instr_i;

        if (flush_i) begin
            state_d = S_DEC;
        end else begin
            case (state_q)
                S_DEC: begin
                    if (instr_valid_i) begin
                        if (hazard) begin
                            held_d       = instr_i;
                            stall_left_d = STALL_INIT;
                            stall_bubble = 1'b1;
                            state_d      = S_STALL;
                        end else begin
                            issue_en = 1'b1;
                        end
                    end
                end
                S_IMM: begin
                    if (instr_valid_i) begin
                        ctrl_d.opcode   = instr_i[7:4];
                        ctrl_d.ra_add   = instr_i[1:0];
                        ctrl_d.rb_add   = ldm_rb_q;
                        ctrl_d.cu_input = CU_IMM;
                        ctrl_d.rb_en    = 1'b1;
                        state_d         = S_DEC;
                    end
                end
                S_STALL: begin
                    if (stall_left_q == 2'd0) begin
                        issue_en   = 1'b1;
                        issue_byte = held_q;
                    end else begin
                        stall_left_d = stall_left_q - 2'd1;
                        stall_bubble = 1'b1;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: state_d = S_DEC;
            endcase
        end

        if (issue_en) begin
            state_d = S_DEC;
            if (is_ldm(issue_byte)) begin
                ldm_rb_d = issue_byte[1:0];
                state_d  = S_IMM;
            end else if (is_hlt(issue_byte)) begin
                state_d = S_HALT;
            end else begin
                ctrl_d = decode_instr(issue_byte);
            end
        end
    end

    // State and output registers. Reset lands in S_DEC with a bubble on the
    // outputs, so a reset mid-LDM or mid-stall never leaks a partial write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_DEC;
            ctrl_q       <= CTRL_BUBBLE;
            held_q       <= '0;
            ldm_rb_q     <= '0;
            stall_left_q <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            held_q       <= held_d;
            ldm_rb_q     <= ldm_rb_d;
            stall_left_q <= stall_left_d;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Counts each bubble that exists only because of a load-use hazard,
    // sticking at all-ones rather than wrapping.
    logic [CNT_W-1:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (stall_bubble && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//  Self-checking bench for instr_decode_stage: directed scenarios followed
//  by randomized traffic, all checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam int STALL_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr_i;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic       flush_i;
    logic [3:0] opcode_o;
    logic [1:0] ra_add_o;
    logic [1:0] rb_add_o;
    logic [3:0] cu_input_o;
    logic       ra_en_o, rb_en_o, flags_en_o;
    logic       mem_rd_o, mem_wr_o, port_out_o, branch_o, halted_o;
`ifdef DECODE_PERF_CNT_EN
    logic [15:0] perf_stall_cnt_o;
`endif

    instr_decode_stage #(
        .DATA_W       (8),
        .STALL_CYCLES (STALL_CYCLES)
`ifdef DECODE_PERF_CNT_EN
        ,
        .CNT_W        (16)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_i          (instr_i),
        .instr_valid_i    (instr_valid_i),
        .instr_ready_o    (instr_ready_o),
        .flush_i          (flush_i),
        .opcode_o         (opcode_o),
        .ra_add_o         (ra_add_o),
        .rb_add_o         (rb_add_o),
        .cu_input_o       (cu_input_o),
        .ra_en_o          (ra_en_o),
        .rb_en_o          (rb_en_o),
        .flags_en_o       (flags_en_o),
        .mem_rd_o         (mem_rd_o),
        .mem_wr_o         (mem_wr_o),
        .port_out_o       (port_out_o),
        .branch_o         (branch_o),
        .halted_o         (halted_o)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed control word, packed in the same order as the model's:
    // {opcode, ra, rb, cu, ra_en, rb_en, flags_en, mem_rd, mem_wr, port, branch}
    logic [18:0] dut_ctrl;
    assign dut_ctrl = {opcode_o, ra_add_o, rb_add_o, cu_input_o, ra_en_o, rb_en_o,
                       flags_en_o, mem_rd_o, mem_wr_o, port_out_o, branch_o};

    // Behavioural model state, written in terms of what the stage is doing
    // rather than how the hardware encodes it.
    logic [18:0] m_out;
    bit          m_wait_imm;
    logic [1:0]  m_imm_rb;
    bit          m_stalled;
    int          m_stall_left;
    logic [7:0]  m_held;
    bit          m_halted;
    int          m_perf;

    // Single comparison point: counts, and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference control word from the ISA table, field by field.
    function automatic logic [18:0] expectedCtrl(input logic [7:0] b);
        int         op, ra;
        logic       w_ra, w_rb, fl, rd, wr, po, br;
        logic [3:0] cu;
        op = int'(b[7:4]);
        ra = int'(b[3:2]);
        if (op == 0 || op >= 14 || (op == 12 && ra == 0))
            return 19'd0;
        w_ra = (op >= 1 && op <= 5);
        fl   = (op >= 2 && op <= 6) || op == 8;
        w_rb = (op == 6 && ra < 2) || (op == 7 && (ra == 1 || ra == 3)) || op == 8 ||
               (op == 12 && ra == 1) || op == 13;
        rd   = (op == 7 && ra == 1) || (op == 12 && ra == 1) || op == 13;
        wr   = (op == 7 && ra == 0) || (op == 12 && ra >= 2);
        po   = (op == 7 && ra == 2);
        br   = (op >= 9 && op <= 11);
        cu   = 4'd0;
        if (op == 6 && ra == 0) cu = 4'd8;
        if (op == 6 && ra == 1) cu = 4'd12;
        if (op == 7 && ra == 3) cu = 4'd1;
        if (op == 8)            cu = 4'd3;
        return {b[7:4], b[3:2], b[1:0], cu, w_ra, w_rb, fl, rd, wr, po, br};
    endfunction

    task automatic modelReset();
        m_out        = '0;
        m_wait_imm   = 0;
        m_imm_rb     = '0;
        m_stalled    = 0;
        m_stall_left = 0;
        m_held       = '0;
        m_halted     = 0;
        m_perf       = 0;
    endtask

    // Start executing one instruction byte in the model.
    task automatic modelIssue(input logic [7:0] b);
        m_out = expectedCtrl(b);
        if (b[7:2] == 6'b110000) begin
            m_wait_imm = 1;
            m_imm_rb   = b[1:0];
        end else if (b[7:2] == 6'b000001) begin
            m_halted = 1;
        end
    endtask

    // One clock of the model, given what fetch and the flush line present.
    task automatic modelStep(input bit valid, input logic [7:0] b, input bit flush);
        bit         last_load;
        logic [1:0] tag;
        last_load = m_out[5] && (m_out[10:7] == 4'd0);
        tag       = m_out[12:11];
        m_out     = '0;
        if (flush) begin
            m_wait_imm = 0;
            m_stalled  = 0;
            m_halted   = 0;
        end else if (m_halted) begin
            m_out = '0;
        end else if (m_stalled) begin
            if (m_stall_left > 0) begin
                m_stall_left--;
                m_perf++;
            end else begin
                m_stalled = 0;
                modelIssue(m_held);
            end
        end else if (m_wait_imm) begin
            if (valid) begin
                m_out      = {b[7:4], b[1:0], m_imm_rb, 4'd2, 7'b0100000};
                m_wait_imm = 0;
            end
        end else if (valid) begin
            if (last_load && (b[3:2] == tag || b[1:0] == tag)) begin
                m_stalled    = 1;
                m_held       = b;
                m_stall_left = STALL_CYCLES - 1;
                m_perf++;
            end else begin
                modelIssue(b);
            end
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge and the
    // registered outputs after it.
    task automatic applyStimulus(input bit valid, input logic [7:0] b, input bit flush,
                                 input string tag);
        @(negedge clk);
        instr_valid_i = valid;
        instr_i       = b;
        flush_i       = flush;
        #1;
        checkOutput({tag, "_ready"}, 32'(instr_ready_o),
                    32'(flush || !(m_stalled || m_halted)));
        modelStep(valid, b, flush);
        @(posedge clk);
        #1;
        checkOutput({tag, "_ctrl"}, 32'(dut_ctrl), 32'(m_out));
        checkOutput({tag, "_halt"}, 32'(halted_o), 32'(m_halted));
`ifdef DECODE_PERF_CNT_EN
        checkOutput({tag, "_perf"}, 32'(perf_stall_cnt_o), 32'(m_perf));
`endif
    endtask

    // Asynchronous reset held for two clocks, checked while asserted.
    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n         = 1'b0;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        #1;
        checkOutput({tag, "_async_ctrl"}, 32'(dut_ctrl), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_rst_ctrl"}, 32'(dut_ctrl), 32'd0);
        checkOutput({tag, "_rst_ready"}, 32'(instr_ready_o), 32'd1);
        checkOutput({tag, "_rst_halt"}, 32'(halted_o), 32'd0);
`ifdef DECODE_PERF_CNT_EN
        checkOutput({tag, "_rst_perf"}, 32'(perf_stall_cnt_o), 32'd0);
`endif
        modelReset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bit         v, f;

        rst_n         = 1'b1;
        instr_i       = '0;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        modelReset();
        doReset("reset");

        // ADD R1,R2
        applyStimulus(1, 8'h26, 0, "add");
        checkOutput("add_ra_en", 32'(ra_en_o), 32'd1);
        checkOutput("add_flags", 32'(flags_en_o), 32'd1);
        checkOutput("add_ra", 32'(ra_add_o), 32'd1);
        checkOutput("add_rb", 32'(rb_add_o), 32'd2);
        checkOutput("add_rb_en", 32'(rb_en_o), 32'd0);

        // LDM R3, #0xA5
        applyStimulus(1, 8'hC3, 0, "ldm");
        checkOutput("ldm_bubble", 32'(dut_ctrl), 32'd0);
        applyStimulus(1, 8'hA5, 0, "ldm_imm");
        checkOutput("imm_rb_en", 32'(rb_en_o), 32'd1);
        checkOutput("imm_cu", 32'(cu_input_o), 32'd2);
        checkOutput("imm_opcode", 32'(opcode_o), 32'hA);
        checkOutput("imm_rb", 32'(rb_add_o), 32'd3);
        checkOutput("imm_ra", 32'(ra_add_o), 32'd1);

        // LDD R2 then ADD R2,R0: one load-use bubble
        applyStimulus(1, 8'hC6, 0, "ldd");
        checkOutput("ldd_mem_rd", 32'(mem_rd_o), 32'd1);
        applyStimulus(1, 8'h28, 0, "use");
        checkOutput("use_bubble", 32'(dut_ctrl), 32'd0);
        checkOutput("stall_ready", 32'(instr_ready_o), 32'd0);
        applyStimulus(1, 8'h28, 0, "stall");
        checkOutput("held_add_ra_en", 32'(ra_en_o), 32'd1);
        checkOutput("held_add_ra", 32'(ra_add_o), 32'd2);
`ifdef DECODE_PERF_CNT_EN
        checkOutput("stall_perf", 32'(perf_stall_cnt_o), 32'd1);
`endif
        applyStimulus(0, 8'h00, 0, "idle");

        // LDM R1 killed by a flush
        applyStimulus(1, 8'hC1, 0, "ldm_fl");
        applyStimulus(1, 8'h55, 1, "flush");
        checkOutput("flush_bubble", 32'(dut_ctrl), 32'd0);
        applyStimulus(1, 8'h26, 0, "post_flush");
        checkOutput("post_flush_ra_en", 32'(ra_en_o), 32'd1);
        checkOutput("post_flush_rb_en", 32'(rb_en_o), 32'd0);

        // HLT holds for 10 cycles, reset exits
        applyStimulus(1, 8'h04, 0, "hlt");
        checkOutput("hlt_halted", 32'(halted_o), 32'd1);
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 8'h26, 0, "halted");
        doReset("hlt_exit");

        // Reset in the middle of a stall
        applyStimulus(1, 8'hD1, 0, "ld_r1");
        applyStimulus(1, 8'h14, 0, "use_r1");
        doReset("mid_stall");

        // Randomized traffic with biased loads; HLT is kept out so the run
        // keeps making progress.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 19) == 0);
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = {4'hD, b[3:0]};
            if ($urandom_range(0, 7) == 0) b = {4'hC, 2'b00, b[1:0]};
            if (b[7:2] == 6'b000001) b = 8'h26;
            applyStimulus(v, b, f, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
